// File: rtl/strand_select_stage.sv
// Round-robin issue arbiter between the strand FSMs and decode, plus the
// strand-select pipeline register that feeds decode.
module strand_select_stage #(
    parameter int NUM_STRANDS = 4,
    parameter int SW          = $clog2(NUM_STRANDS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_STRANDS-1:0]    strand_ready,
    output logic [NUM_STRANDS-1:0]    issue_strand_oh,
    input  logic [32*NUM_STRANDS-1:0] if_instruction,
    input  logic [4*NUM_STRANDS-1:0]  reg_lane_select,
    input  logic [NUM_STRANDS-1:0]    rb_rollback_strand,
    input  logic                      ds_stall,
    output logic                      ss_valid,
    output logic [31:0]               ss_instruction,
    output logic [SW-1:0]             ss_strand_id,
    output logic [3:0]                ss_reg_lane_select
);

    logic [NUM_STRANDS-1:0] elig;
    logic [31:0]            inst_arr [NUM_STRANDS];
    logic [3:0]             lane_arr [NUM_STRANDS];
    logic                   grant_found;
    logic [SW-1:0]          grant_idx;
    logic [SW-1:0]          scan_idx;

    logic [SW-1:0] rr_ptr_q, rr_ptr_d;
    logic          ss_valid_q, ss_valid_d;
    logic [31:0]   ss_instruction_q, ss_instruction_d;
    logic [SW-1:0] ss_strand_id_q, ss_strand_id_d;
    logic [3:0]    ss_lane_q, ss_lane_d;

    always_comb begin
        for (int i = 0; i < NUM_STRANDS; i++) begin
            inst_arr[i] = if_instruction[32*i +: 32];
            lane_arr[i] = reg_lane_select[4*i +: 4];
        end
    end

    assign elig = strand_ready & ~rb_rollback_strand & {NUM_STRANDS{~ds_stall}};

    // NUM_STRANDS is a power of two, so SW-bit addition wraps the search naturally.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int off = 0; off < NUM_STRANDS; off++) begin
            scan_idx = rr_ptr_q + SW'(off);
            if (!grant_found && elig[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
        if (!reset_n) begin
            grant_found = 1'b0;
        end
    end

    always_comb begin
        issue_strand_oh            = '0;
        issue_strand_oh[grant_idx] = grant_found;
    end

    always_comb begin
        rr_ptr_d         = rr_ptr_q;
        ss_valid_d       = ss_valid_q;
        ss_instruction_d = ss_instruction_q;
        ss_strand_id_d   = ss_strand_id_q;
        ss_lane_d        = ss_lane_q;
        // A grant always wins: eligibility already excludes stalled and rolled-back strands.
        if (grant_found) begin
            rr_ptr_d         = grant_idx + SW'(1);
            ss_valid_d       = 1'b1;
            ss_instruction_d = inst_arr[grant_idx];
            ss_strand_id_d   = grant_idx;
            ss_lane_d        = lane_arr[grant_idx];
        end else if (ss_valid_q && rb_rollback_strand[ss_strand_id_q]) begin
            ss_valid_d = 1'b0;
        end else if (!ds_stall) begin
            ss_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q         <= '0;
            ss_valid_q       <= 1'b0;
            ss_instruction_q <= 32'h0;
            ss_strand_id_q   <= '0;
            ss_lane_q        <= 4'hF;
        end else begin
            rr_ptr_q         <= rr_ptr_d;
            ss_valid_q       <= ss_valid_d;
            ss_instruction_q <= ss_instruction_d;
            ss_strand_id_q   <= ss_strand_id_d;
            ss_lane_q        <= ss_lane_d;
        end
    end

    assign ss_valid           = ss_valid_q;
    assign ss_instruction     = ss_instruction_q;
    assign ss_strand_id       = ss_strand_id_q;
    assign ss_reg_lane_select = ss_lane_q;

endmodule

// File: tb/tb_strand_select_stage.sv
// Self-checking bench for strand_select_stage: directed scenarios followed by
// randomized traffic against a behavioural round-robin/pipeline model.
module tb_strand_select_stage;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   strand_ready;
    logic [N-1:0]   issue_strand_oh;
    logic [32*N-1:0] if_instruction;
    logic [4*N-1:0] reg_lane_select;
    logic [N-1:0]   rb_rollback_strand;
    logic           ds_stall;
    logic           ss_valid;
    logic [31:0]    ss_instruction;
    logic [1:0]     ss_strand_id;
    logic [3:0]     ss_reg_lane_select;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    int          m_ptr;
    bit          m_valid;
    logic [31:0] m_inst;
    int          m_sid;
    logic [3:0]  m_lane;

    logic [N-1:0] oh_seen;

    strand_select_stage #(.NUM_STRANDS(N)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .strand_ready       (strand_ready),
        .issue_strand_oh    (issue_strand_oh),
        .if_instruction     (if_instruction),
        .reg_lane_select    (reg_lane_select),
        .rb_rollback_strand (rb_rollback_strand),
        .ds_stall           (ds_stall),
        .ss_valid           (ss_valid),
        .ss_instruction     (ss_instruction),
        .ss_strand_id       (ss_strand_id),
        .ss_reg_lane_select (ss_reg_lane_select)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 0;
        m_inst  = 32'h0;
        m_sid   = 0;
        m_lane  = 4'hF;
    endtask

    task automatic check_ss();
        check("ss_valid", ss_valid, m_valid);
        check("ss_instruction", ss_instruction, m_inst);
        check("ss_strand_id", ss_strand_id, m_sid);
        check("ss_lane", ss_reg_lane_select, m_lane);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Entered at a falling edge; leaves at the next falling edge.
    task automatic step(input logic [N-1:0] rdy, input logic [N-1:0] rb, input logic st,
                        input logic [127:0] ins, input logic [15:0] lanes,
                        output logic [N-1:0] oh);
        int g;
        logic [N-1:0] exp_oh;
        check_ss();
        strand_ready       = rdy;
        rb_rollback_strand = rb;
        ds_stall           = st;
        if_instruction     = ins;
        reg_lane_select    = lanes;
        #1;
        g = -1;
        for (int o = 0; o < N; o++) begin
            int k;
            k = (m_ptr + o) % N;
            if (g < 0 && rdy[k] && !rb[k] && !st) g = k;
        end
        exp_oh = '0;
        if (g >= 0) exp_oh[g] = 1'b1;
        oh = issue_strand_oh;
        check("issue_oh", issue_strand_oh, exp_oh);
        @(posedge clk);
        if (m_valid && rb[m_sid]) m_valid = 0;
        if (!st) begin
            if (g >= 0) begin
                m_valid = 1;
                m_inst  = ins[32*g +: 32];
                m_sid   = g;
                m_lane  = lanes[4*g +: 4];
                m_ptr   = (g + 1) % N;
            end else begin
                m_valid = 0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] ins;
        reset_n            = 1'b0;
        strand_ready       = '1;
        rb_rollback_strand = '0;
        ds_stall           = 1'b0;
        if_instruction     = rnd128();
        reg_lane_select    = 16'h1234;
        model_reset();
        #12;
        check("reset_oh", issue_strand_oh, 4'b0000);
        check("reset_lane", ss_reg_lane_select, 4'hF);
        check_ss();
        @(negedge clk);
        reset_n = 1'b1;

        // all ready: grants rotate 0,1,2,3,0,...
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, 4'b0000, 1'b0, rnd128(), 16'($urandom), oh_seen);
            check("s1_rotate", oh_seen, 4'b0001 << (i % 4));
        end
        check("s1_sid_lag", ss_strand_id, 2'd3);

        // push pointer to 3, then a lone strand 2 forces a wrapping search
        step(4'b0100, 4'b0000, 1'b0, rnd128(), 16'($urandom), oh_seen);
        step(4'b0100, 4'b0000, 1'b0, rnd128(), 16'($urandom), oh_seen);
        check("s2_wrap", oh_seen, 4'b0100);
        step(4'b1100, 4'b0000, 1'b0, rnd128(), 16'($urandom), oh_seen);
        check("s2_next", oh_seen, 4'b1000);
        step(4'b1111, 4'b0000, 1'b0, rnd128(), 16'($urandom), oh_seen);
        check("s2_ptr0", oh_seen, 4'b0001);

        // grant strand 1 then stall for 3 cycles
        ins = rnd128();
        ins[63:32] = 32'hC0DE0001;
        step(4'b0010, 4'b0000, 1'b0, ins, 16'($urandom), oh_seen);
        check("s3_grant1", oh_seen, 4'b0010);
        for (int i = 0; i < 3; i++) begin
            step(4'b1111, 4'b0000, 1'b1, rnd128(), 16'($urandom), oh_seen);
            check("s3_stall_oh", oh_seen, 4'b0000);
            check("s3_hold_inst", ss_instruction, 32'hC0DE0001);
            check("s3_hold_valid", ss_valid, 1'b1);
        end

        // squash strand 1 while strand 0 issues
        step(4'b0011, 4'b0010, 1'b0, rnd128(), 16'($urandom), oh_seen);
        check("s4_grant0", oh_seen, 4'b0001);
        check("s4_valid", ss_valid, 1'b1);
        check("s4_sid", ss_strand_id, 2'd0);

        // squash under stall
        step(4'b0010, 4'b0000, 1'b0, rnd128(), 16'($urandom), oh_seen);
        check("s5_grant1", oh_seen, 4'b0010);
        step(4'b1111, 4'b0010, 1'b1, rnd128(), 16'($urandom), oh_seen);
        check("s5_oh", oh_seen, 4'b0000);
        check("s5_valid", ss_valid, 1'b0);

        // asynchronous reset mid-stream
        step(4'b1111, 4'b0000, 1'b0, rnd128(), 16'($urandom), oh_seen);
        check("s6_valid_before", ss_valid, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("s6_rst_oh", issue_strand_oh, 4'b0000);
        check_ss();
        @(negedge clk);
        reset_n = 1'b1;
        step(4'b0110, 4'b0000, 1'b0, rnd128(), 16'($urandom), oh_seen);
        check("s6_first", oh_seen, 4'b0010);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] rdy, rb;
            logic st;
            rdy = N'($urandom);
            rb  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            st  = ($urandom_range(0, 4) == 0);
            step(rdy, rb, st, rnd128(), 16'($urandom), oh_seen);
        end
        check_ss();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/strand_select_stage.md
# strand_select_stage

Round-robin issue arbiter between the per-strand state machines and the decode stage. Each cycle it grants exactly one ready strand (or none), returns the one-hot grant to the strand FSMs as their issue permission, and registers the granted strand's instruction, strand ID and vector lane select into the pipeline register that feeds decode. It also honours a downstream stall and squashes a registered instruction whose strand is rolled back.

## Interface
- NUM_STRANDS, 4: number of hardware strands; power of two, 2..8.
- SW, $clog2(NUM_STRANDS): strand ID width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- strand_ready  in  NUM_STRANDS  bit i: strand i has a valid instruction and may issue.
- issue_strand_oh  out  NUM_STRANDS  one-hot grant, combinational; zero when nothing is granted.
- if_instruction  in  32*NUM_STRANDS  strand i's instruction in bits [32i+31:32i].
- reg_lane_select  in  4*NUM_STRANDS  strand i's current lane in bits [4i+3:4i].
- rb_rollback_strand  in  NUM_STRANDS  per-strand rollback from the rollback controller.
- ds_stall  in  1  decode cannot accept a new instruction this cycle.
- ss_valid  out  1  registered: ss_* fields hold a live instruction.
- ss_instruction  out  32  registered instruction.
- ss_strand_id  out  SW  registered strand index.
- ss_reg_lane_select  out  4  registered lane select.

## Operation
- Eligibility: elig[i] = strand_ready[i] & !rb_rollback_strand[i] & !ds_stall.
- Priority pointer rr_ptr (SW bits):
  - Grant the first eligible strand found by searching rr_ptr, rr_ptr+1, … modulo NUM_STRANDS.
  - issue_strand_oh has that bit set and all others zero. With no eligible strand it is all zero.
- Pointer update:
  - On a grant of strand k, rr_ptr <= (k+1) mod NUM_STRANDS. Wrap from NUM_STRANDS-1 to 0 is required.
  - With no grant, rr_ptr holds.
- Pipeline register, in this priority order at each edge:
  1. Squash: ss_valid & rb_rollback_strand[ss_strand_id] forces ss_valid <= 0. This applies even under ds_stall. The data fields may hold.
  2. Stall: ds_stall holds all ss_* fields unchanged.
  3. Grant of strand k loads:
     - ss_valid <= 1
     - ss_instruction <= slice k of if_instruction
     - ss_strand_id <= k
     - ss_reg_lane_select <= slice k of reg_lane_select
  4. Otherwise ss_valid <= 0 and the fields hold.
- Squash and a new grant in the same cycle: the grant is loaded, because the granted strand differs from the rolled-back strand by eligibility. ss_valid ends at 1.
- Every issue_strand_oh pulse must produce exactly one ss_valid cycle. The only exception is a squash in the following cycle.
- Issue permission is never granted to a strand in the cycle its rollback is asserted.
- Reset (reset_n low, asynchronous):
  - ss_valid=0
  - ss_instruction=32'h0
  - ss_strand_id=0
  - ss_reg_lane_select=4'hF
  - rr_ptr=0
  - issue_strand_oh is 0 while reset_n is low.
- Reset mid-operation discards any registered instruction. No grant is issued until the first edge after reset_n rises.

## Timing
- Grant latency: issue_strand_oh is valid in the same cycle as strand_ready. It is purely combinational from strand_ready, rb_rollback_strand, ds_stall and rr_ptr.
- Required properties of the grant path:
  - No combinational path from issue_strand_oh back to strand_ready inside this block.
  - The strand FSMs may use issue_strand_oh combinationally.
- Data latency: a grant in cycle n appears on ss_* after the edge ending cycle n, i.e. one cycle.
- Throughput: one instruction per cycle when not stalled. Up to NUM_STRANDS consecutive grants to distinct strands.
- Fairness: a continuously ready strand is granted within NUM_STRANDS unstalled cycles.
- ds_stall is sampled in the same cycle it suppresses grants. No grant is lost or duplicated across a stall boundary.

## Test plan
- Reset then all four strands ready, no stall for 8 cycles -> grants 0,1,2,3,0,1,2,3. ss_strand_id lags by one cycle. ss_valid=1 from cycle 2.
- Only strand 2 ready, rr_ptr=3 -> search wraps and grants strand 2; rr_ptr becomes 3. Next cycle strands 2 and 3 ready -> strand 3 granted, rr_ptr=0.
- Grant strand 1 with instruction 32'hC0DE0001, then ds_stall=1 for 3 cycles -> issue_strand_oh=0 during the stall. ss_instruction holds 32'hC0DE0001 with ss_valid=1 throughout.
- ss_strand_id=1 valid, rb_rollback_strand=4'b0010 while strand 0 is ready -> ss_valid stays 1 with ss_strand_id=0. The strand-1 instruction is squashed, and strand 1 is not granted that cycle even if strand_ready[1]=1.
- Same squash under ds_stall=1 -> ss_valid drops to 0 and no grant is issued.
- Assert reset_n low mid-stream with ss_valid=1 -> all outputs return to their reset values immediately. The first grant after release is to the lowest-index ready strand.
